// File: rtl/hiscore_ram_arbiter_if.sv
// Bus bundle between the CPU, the work-RAM and the hiscore/autosave engines.
// The slave modport is the arbiter's view of this bundle.
interface hiscore_ram_arbiter_if #(
   parameter int unsigned AW = 10
) ();
   logic [AW-1:0] cpu_addr;
   logic [7:0]    cpu_wdata;
   logic          cpu_we;
   logic          cpu_pause;
   logic          cpu_halted;

   logic          hs_req;
   logic [AW-1:0] hs_addr;
   logic [7:0]    hs_wdata;
   logic          hs_we;
   logic          hs_gnt;
   logic          hs_rvalid;

   logic          sv_req;
   logic [AW-1:0] sv_addr;
   logic [7:0]    sv_wdata;
   logic          sv_we;
   logic          sv_gnt;
   logic          sv_rvalid;

   logic [AW-1:0] ram_addr;
   logic [7:0]    ram_wdata;
   logic          ram_we;
   logic [7:0]    ram_rdata;

   logic          busy;

   modport slave (
      input  cpu_addr, cpu_wdata, cpu_we, cpu_halted,
      input  hs_req, hs_addr, hs_wdata, hs_we,
      input  sv_req, sv_addr, sv_wdata, sv_we,
      input  ram_rdata,
      output cpu_pause, hs_gnt, hs_rvalid, sv_gnt, sv_rvalid,
      output ram_addr, ram_wdata, ram_we, busy
   );

   modport master (
      output cpu_addr, cpu_wdata, cpu_we, cpu_halted,
      output hs_req, hs_addr, hs_wdata, hs_we,
      output sv_req, sv_addr, sv_wdata, sv_we,
      output ram_rdata,
      input  cpu_pause, hs_gnt, hs_rvalid, sv_gnt, sv_rvalid,
      input  ram_addr, ram_wdata, ram_we, busy
   );
endinterface

// File: rtl/hiscore_ram_arbiter.sv
// Work-RAM port arbiter: pauses the CPU, then grants the RAM round-robin to the
// hiscore and NVRAM/autosave engines before handing the port back to the CPU.
module hiscore_ram_arbiter #(
   parameter int unsigned AW     = 10,
   parameter int unsigned SETTLE = 3
) (
   input logic                  clk,
   input logic                  reset_n,
   hiscore_ram_arbiter_if.slave bus
);

   localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

   typedef enum logic [2:0] {
      StIdle, StHaltWait, StSettle, StGrant, StSwitch, StRelease
   } state_e;

   state_e        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          last_sv_q, last_sv_d;
   logic [AW-1:0] addr_q;
   logic [7:0]    wdata_q;
   logic          hs_rvalid_q, sv_rvalid_q;

   logic          any_req, pick_sv, owner_req, other_req;
   logic [AW-1:0] mux_addr;
   logic [7:0]    mux_wdata;
   logic          mux_we;

   assign any_req   = bus.hs_req | bus.sv_req;
   // sv wins when it is the only requester, or when hs had the previous turn
   assign pick_sv   = bus.sv_req & (~bus.hs_req | ~last_sv_q);
   assign owner_req = last_sv_q ? bus.sv_req : bus.hs_req;
   assign other_req = last_sv_q ? bus.hs_req : bus.sv_req;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      last_sv_d = last_sv_q;
      unique case (state_q)
         StIdle: begin
            if (any_req) state_d = StHaltWait;
         end
         StHaltWait: begin
            if (!any_req) begin
               state_d = StRelease;
            end else if (bus.cpu_halted) begin
               state_d = StSettle;
               cnt_d   = 4'd0;
            end
         end
         StSettle: begin
            if (!any_req) begin
               state_d = StRelease;
            end else if (cnt_q == SettleLast) begin
               state_d   = StGrant;
               last_sv_d = pick_sv;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StGrant: begin
            if (!owner_req) state_d = other_req ? StSwitch : StRelease;
         end
         StSwitch: begin
            if (any_req) begin
               state_d   = StGrant;
               last_sv_d = pick_sv;
            end else begin
               state_d = StRelease;
            end
         end
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Outside IDLE and GRANT the address/data are parked and writes are blocked.
   always_comb begin
      mux_addr  = addr_q;
      mux_wdata = wdata_q;
      mux_we    = 1'b0;
      case (state_q)
         StIdle: begin
            mux_addr  = bus.cpu_addr;
            mux_wdata = bus.cpu_wdata;
            mux_we    = bus.cpu_we;
         end
         StGrant: begin
            if (last_sv_q) begin
               mux_addr  = bus.sv_addr;
               mux_wdata = bus.sv_wdata;
               mux_we    = bus.sv_we;
            end else begin
               mux_addr  = bus.hs_addr;
               mux_wdata = bus.hs_wdata;
               mux_we    = bus.hs_we;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         last_sv_q   <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= 8'h00;
         hs_rvalid_q <= 1'b0;
         sv_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         last_sv_q   <= last_sv_d;
         addr_q      <= mux_addr;
         wdata_q     <= mux_wdata;
         hs_rvalid_q <= (state_q == StGrant) & ~last_sv_q & ~bus.hs_we;
         sv_rvalid_q <= (state_q == StGrant) & last_sv_q & ~bus.sv_we;
      end
   end

   assign bus.ram_addr  = mux_addr;
   assign bus.ram_wdata = mux_wdata;
   assign bus.ram_we    = mux_we;

   // Pause stays up through RELEASE so the CPU resumes only once the mux is back.
   assign bus.cpu_pause = (state_q != StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.hs_gnt    = (state_q == StGrant) & ~last_sv_q;
   assign bus.sv_gnt    = (state_q == StGrant) & last_sv_q;
   assign bus.hs_rvalid = hs_rvalid_q;
   assign bus.sv_rvalid = sv_rvalid_q;

endmodule

// File: tb/tb_hiscore_ram_arbiter.sv
// Self-checking bench for hiscore_ram_arbiter: per-cycle timeline checks plus a
// read-data scoreboard fed by a behavioural synchronous RAM.
module tb_hiscore_ram_arbiter;

   logic clk;
   logic reset_n;
   logic mem_init;
   int   checks;
   int   errors;

   logic [7:0] mem     [1024];
   logic [7:0] ref_mem [1024];
   logic [7:0] hs_exp[$];
   logic [7:0] sv_exp[$];

   hiscore_ram_arbiter_if #(.AW(10)) bus ();

   hiscore_ram_arbiter #(.AW(10), .SETTLE(3)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] pat(input int i);
      logic [9:0] a;
      a = 10'(i);
      if (a == 10'h3A0) return 8'h5C;
      return a[7:0] ^ 8'h5A;
   endfunction

   // Synchronous RAM, one-cycle read latency, read-before-write.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
      end else if (bus.ram_we) begin
         mem[bus.ram_addr] <= bus.ram_wdata;
      end
      bus.ram_rdata <= mem[bus.ram_addr];
   end

   // Scoreboard: every rvalid pops the oldest expected read for that requester.
   always @(negedge clk) begin
      logic [7:0] e;
      if (bus.hs_rvalid === 1'b1) begin
         checks++;
         if (hs_exp.size() == 0) begin
            errors++;
            $display("FAIL hs_rvalid_unexpected: got rdata %h, required no rvalid", bus.ram_rdata);
         end else begin
            e = hs_exp.pop_front();
            if (bus.ram_rdata !== e) begin
               errors++;
               $display("FAIL hs_rdata: got %h, required %h", bus.ram_rdata, e);
            end
         end
      end
      if (bus.sv_rvalid === 1'b1) begin
         checks++;
         if (sv_exp.size() == 0) begin
            errors++;
            $display("FAIL sv_rvalid_unexpected: got rdata %h, required no rvalid", bus.ram_rdata);
         end else begin
            e = sv_exp.pop_front();
            if (bus.ram_rdata !== e) begin
               errors++;
               $display("FAIL sv_rdata: got %h, required %h", bus.ram_rdata, e);
            end
         end
      end
      if (bus.hs_gnt === 1'b1 && bus.sv_gnt === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL dual_grant: got hs_gnt=1 sv_gnt=1, required at most one");
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [6:0] got;
      reset_n        = 1'b0;
      mem_init       = 1'b1;
      bus.cpu_addr   = 10'h033;
      bus.cpu_wdata  = 8'h00;
      bus.cpu_we     = 1'b0;
      bus.cpu_halted = 1'b0;
      bus.hs_req = 1'b0; bus.hs_addr = '0; bus.hs_wdata = '0; bus.hs_we = 1'b0;
      bus.sv_req = 1'b0; bus.sv_addr = '0; bus.sv_wdata = '0; bus.sv_we = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      got = {bus.cpu_pause, bus.hs_gnt, bus.sv_gnt, bus.hs_rvalid, bus.sv_rvalid,
             bus.busy, bus.ram_we};
      checks++;
      if (got !== 7'b0) begin
         errors++;
         $display("FAIL reset_outputs: got %b, required 0000000", got);
      end
      checks++;
      if (bus.ram_addr !== 10'h033) begin
         errors++;
         $display("FAIL reset_mux: got ram_addr %h, required 033", bus.ram_addr);
      end
      next_cycle();
      reset_n      = 1'b1;
      mem_init     = 1'b0;
      bus.cpu_addr = 10'h0F0;
   endtask

   task automatic test_passthrough();
      bus.cpu_we    = 1'b1;
      bus.cpu_addr  = 10'h015;
      bus.cpu_wdata = 8'hAA;
      @(negedge clk);
      checks++;
      if ({bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.busy} !== {1'b1, 10'h015, 8'hAA, 1'b0})
      begin
         errors++;
         $display("FAIL passthrough: got we=%b addr=%h wdata=%h busy=%b, required 1 015 aa 0",
                  bus.ram_we, bus.ram_addr, bus.ram_wdata, bus.busy);
      end
      ref_mem[10'h015] = 8'hAA;
      next_cycle();
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 10'h0F0;
      @(negedge clk);
      checks++;
      if (bus.ram_we !== 1'b0 || bus.ram_addr !== 10'h0F0) begin
         errors++;
         $display("FAIL passthrough_idle: got we=%b addr=%h, required 0 0f0",
                  bus.ram_we, bus.ram_addr);
      end
      next_cycle();
   endtask

   // Both engines request together; the first owner writes, the second reads it back.
   task automatic test_back_to_back(input bit sv_first, input logic [9:0] base);
      logic       f_req, f_we, s_req, s_we, f_gnt, s_gnt, exp_pause;
      logic [9:0] f_addr, s_addr;
      logic [7:0] f_wd;
      logic [4:0] exp_v, got_v;
      for (int c = 0; c < 19; c++) begin
         f_req  = (c < 10);
         f_we   = (c < 10);
         f_addr = base + 10'(c) - 10'd6;
         f_wd   = 8'hC0 + 8'(c) + (sv_first ? 8'h10 : 8'h00);
         s_req  = (c < 15);
         s_we   = (c < 6) || (c == 11);
         s_addr = base + 10'(c) - 10'd12;
         bus.cpu_halted = (c >= 2) && (c < 17);
         if (sv_first) begin
            bus.sv_req = f_req; bus.sv_we = f_we; bus.sv_addr = f_addr; bus.sv_wdata = f_wd;
            bus.hs_req = s_req; bus.hs_we = s_we; bus.hs_addr = s_addr; bus.hs_wdata = 8'h00;
         end else begin
            bus.hs_req = f_req; bus.hs_we = f_we; bus.hs_addr = f_addr; bus.hs_wdata = f_wd;
            bus.sv_req = s_req; bus.sv_we = s_we; bus.sv_addr = s_addr; bus.sv_wdata = 8'h00;
         end
         exp_pause = (c >= 1) && (c < 17);
         f_gnt     = (c >= 6) && (c <= 10);
         s_gnt     = (c >= 12) && (c <= 15);
         @(negedge clk);
         exp_v = {exp_pause, sv_first ? s_gnt : f_gnt, sv_first ? f_gnt : s_gnt, exp_pause,
                  f_gnt & f_we};
         got_v = {bus.cpu_pause, bus.hs_gnt, bus.sv_gnt, bus.busy, bus.ram_we};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL b2b%0d c=%0d pause/hs/sv/busy/we: got %b, required %b",
                     sv_first, c, got_v, exp_v);
         end
         if (f_gnt) begin
            checks++;
            if (bus.ram_addr !== f_addr) begin
               errors++;
               $display("FAIL b2b%0d c=%0d owner1_addr: got %h, required %h",
                        sv_first, c, bus.ram_addr, f_addr);
            end
            if (f_we) ref_mem[f_addr] = f_wd;
            else if (sv_first) sv_exp.push_back(ref_mem[f_addr]);
            else hs_exp.push_back(ref_mem[f_addr]);
         end
         if (s_gnt) begin
            checks++;
            if (bus.ram_addr !== s_addr) begin
               errors++;
               $display("FAIL b2b%0d c=%0d owner2_addr: got %h, required %h",
                        sv_first, c, bus.ram_addr, s_addr);
            end
            if (sv_first) hs_exp.push_back(ref_mem[s_addr]);
            else sv_exp.push_back(ref_mem[s_addr]);
         end
         if (!exp_pause) begin
            checks++;
            if (bus.ram_addr !== 10'h0F0) begin
               errors++;
               $display("FAIL b2b%0d c=%0d cpu_mux: got %h, required 0f0",
                        sv_first, c, bus.ram_addr);
            end
         end
         next_cycle();
      end
      bus.hs_req = 1'b0; bus.hs_we = 1'b0; bus.sv_req = 1'b0; bus.sv_we = 1'b0;
      bus.cpu_halted = 1'b0;
   endtask

   task automatic test_hs_only();
      logic       exp_pause, exp_gnt;
      logic [4:0] exp_v, got_v;
      for (int c = 0; c < 24; c++) begin
         bus.hs_req     = (c >= 5) && (c < 20);
         bus.hs_we      = 1'b0;
         bus.hs_addr    = 10'h3A0 + 10'(c) - 10'd12;
         bus.cpu_halted = (c >= 8) && (c < 22);
         exp_pause = (c >= 6) && (c < 22);
         exp_gnt   = (c >= 12) && (c <= 20);
         @(negedge clk);
         exp_v = {exp_pause, exp_gnt, 1'b0, exp_pause, 1'b0};
         got_v = {bus.cpu_pause, bus.hs_gnt, bus.sv_gnt, bus.busy, bus.ram_we};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL hs_only c=%0d pause/hs/sv/busy/we: got %b, required %b",
                     c, got_v, exp_v);
         end
         if (exp_gnt) begin
            checks++;
            if (bus.ram_addr !== bus.hs_addr) begin
               errors++;
               $display("FAIL hs_only c=%0d hs_addr: got %h, required %h",
                        c, bus.ram_addr, bus.hs_addr);
            end
            hs_exp.push_back(ref_mem[bus.hs_addr]);
         end
         if (!exp_pause) begin
            checks++;
            if (bus.ram_addr !== 10'h0F0) begin
               errors++;
               $display("FAIL hs_only c=%0d cpu_mux: got %h, required 0f0", c, bus.ram_addr);
            end
         end
         next_cycle();
      end
      bus.hs_req     = 1'b0;
      bus.cpu_halted = 1'b0;
   endtask

   task automatic test_withdraw();
      logic       exp_pause;
      logic [4:0] exp_v, got_v;
      for (int c = 0; c < 6; c++) begin
         bus.hs_req     = (c < 2);
         bus.hs_we      = 1'b1;
         bus.cpu_halted = 1'b0;
         exp_pause = (c >= 1) && (c <= 3);
         @(negedge clk);
         exp_v = {exp_pause, 1'b0, 1'b0, exp_pause, 1'b0};
         got_v = {bus.cpu_pause, bus.hs_gnt, bus.sv_gnt, bus.busy, bus.ram_we};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL withdraw c=%0d pause/hs/sv/busy/we: got %b, required %b",
                     c, got_v, exp_v);
         end
         next_cycle();
      end
      bus.hs_we = 1'b0;
   endtask

   task automatic test_reset_mid_grant();
      logic       exp_pause, exp_gnt;
      logic [9:0] cpu_a;
      logic [4:0] exp_v, got_v;
      for (int c = 0; c < 11; c++) begin
         reset_n        = (c != 7);
         bus.hs_req     = (c < 8);
         bus.hs_we      = 1'b1;
         bus.hs_addr    = 10'h180 + 10'(c);
         bus.hs_wdata   = 8'h40 + 8'(c);
         bus.cpu_halted = (c >= 1) && (c < 8);
         cpu_a          = (c == 9) ? 10'h200 : 10'h0F0;
         bus.cpu_addr   = cpu_a;
         bus.cpu_wdata  = 8'h33;
         bus.cpu_we     = (c == 9);
         exp_pause = (c >= 1) && (c <= 7);
         exp_gnt   = (c >= 5) && (c <= 7);
         @(negedge clk);
         exp_v = {exp_pause, exp_gnt, 1'b0, exp_pause, exp_gnt || (c == 9)};
         got_v = {bus.cpu_pause, bus.hs_gnt, bus.sv_gnt, bus.busy, bus.ram_we};
         checks++;
         if (got_v !== exp_v) begin
            errors++;
            $display("FAIL rst_grant c=%0d pause/hs/sv/busy/we: got %b, required %b",
                     c, got_v, exp_v);
         end
         if (exp_gnt) ref_mem[bus.hs_addr] = bus.hs_wdata;
         if (c >= 8) begin
            checks++;
            if (bus.ram_addr !== cpu_a || bus.hs_rvalid !== 1'b0 || bus.sv_rvalid !== 1'b0) begin
               errors++;
               $display("FAIL rst_grant c=%0d after reset: got addr %h rv %b%b, required %h 00",
                        c, bus.ram_addr, bus.hs_rvalid, bus.sv_rvalid, cpu_a);
            end
         end
         if (c == 9) ref_mem[10'h200] = 8'h33;
         next_cycle();
      end
      bus.hs_we    = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 10'h0F0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_passthrough();
      test_back_to_back(1'b0, 10'h120);
      test_hs_only();
      test_back_to_back(1'b1, 10'h140);
      test_withdraw();
      test_reset_mid_grant();
      test_back_to_back(1'b0, 10'h160);
      repeat (3) next_cycle();
      checks++;
      if (hs_exp.size() != 0 || sv_exp.size() != 0) begin
         errors++;
         $display("FAIL missing_rvalid: got %0d hs and %0d sv reads outstanding, required 0 0",
                  hs_exp.size(), sv_exp.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
